// File: rtl/cache_sa_wb_if.sv
// CPU-side and physical-memory-side signal bundle for cache_sa_wb.
// The cache connects through the slave modport; the CPU/memory side uses master.
interface cache_sa_wb_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WORDS = 8
);
    logic [ADDR_WIDTH-1:0]      mem_address;
    logic                       mem_read;
    logic                       mem_write;
    logic [1:0]                 mem_byte_enable;
    logic [15:0]                mem_wdata;
    logic [15:0]                mem_rdata;
    logic                       mem_resp;
    logic [ADDR_WIDTH-1:0]      pmem_address;
    logic                       pmem_read;
    logic                       pmem_write;
    logic [16*LINE_WORDS-1:0]   pmem_wdata;
    logic [16*LINE_WORDS-1:0]   pmem_rdata;
    logic                       pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU.
// Optional CACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module cache_sa_wb #(
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef CACHE_PERF_CNT_EN
    input  logic        perf_clear,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count,
`endif
    cache_sa_wb_if.slave bus
);
    localparam int unsigned OFF    = $clog2(LINE_WORDS) + 1;
    localparam int unsigned IDX    = $clog2(NUM_SETS);
    localparam int unsigned TAG    = ADDR_WIDTH - IDX - OFF;
    localparam int unsigned LINE_W = 16 * LINE_WORDS;
    localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
    localparam int unsigned PLRU_W = NUM_WAYS - 1;
    localparam int unsigned WSEL_W = OFF - 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t               state_q, state_d;
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
    logic [PLRU_W-1:0]    plru_q  [NUM_SETS];
    logic [TAG-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]    data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]     vict_q;
    logic [TAG-1:0]       miss_tag_q;
    logic [IDX-1:0]       miss_idx_q;

    logic [TAG-1:0]       req_tag;
    logic [IDX-1:0]       req_idx;
    logic [WSEL_W-1:0]    wsel;
    logic                 req, hit, inv_found;
    logic [WAY_W-1:0]     hit_way, inv_way, victim;
    logic [LINE_W-1:0]    hit_line, merge_line;
    logic                 hit_go, miss_go, fill_done, wb_done;
    logic                 unused_addr_lsb;

    // Walk the tree along the LRU pointers to find the victim way.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [NUM_WAYS-1:0] ext;
        logic [WAY_W-1:0]    node, way;
        logic                b;
        ext  = NUM_WAYS'(bits);
        node = '0;
        way  = '0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            b    = ext[node];
            way  = WAY_W'({way, b});
            node = WAY_W'(32'(node) * 2 + 32'(b) + 1);
        end
        return way;
    endfunction

    // Point every node on the path to the accessed way away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [NUM_WAYS-1:0] ext;
        logic [WAY_W-1:0]    node, sh;
        logic                b;
        ext  = NUM_WAYS'(bits);
        node = '0;
        sh   = way;
        for (int l = 0; l < int'(WAY_W); l++) begin
            b         = sh[WAY_W-1];
            ext[node] = ~b;
            node      = WAY_W'(32'(node) * 2 + 32'(b) + 1);
            sh        = sh << 1;
        end
        return ext[PLRU_W-1:0];
    endfunction

    assign req_tag         = bus.mem_address[ADDR_WIDTH-1 -: TAG];
    assign req_idx         = bus.mem_address[OFF +: IDX];
    assign wsel            = bus.mem_address[1 +: WSEL_W];
    assign unused_addr_lsb = bus.mem_address[0];
    assign req             = bus.mem_read | bus.mem_write;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
    end

    // Byte-lane merge of the CPU write word into the hit line.
    always_comb begin
        hit_line   = data_q[req_idx][hit_way];
        merge_line = hit_line;
        if (bus.mem_byte_enable[0]) merge_line[{wsel, 4'd0} +: 8] = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1]) merge_line[{wsel, 4'd8} +: 8] = bus.mem_wdata[15:8];
    end

    assign bus.pmem_wdata = data_q[miss_idx_q][vict_q];

    always_comb begin
        state_d          = state_q;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        hit_go           = 1'b0;
        miss_go          = 1'b0;
        fill_done        = 1'b0;
        wb_done          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    hit_go       = 1'b1;
                    bus.mem_resp = 1'b1;
                    if (!bus.mem_write) bus.mem_rdata = hit_line[{wsel, 4'd0} +: 16];
                end else if (req) begin
                    miss_go = 1'b1;
                    state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
                              ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[miss_idx_q][vict_q], miss_idx_q, OFF'(0)};
                if (bus.pmem_resp) begin
                    wb_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {miss_tag_q, miss_idx_q, OFF'(0)};
                if (bus.pmem_resp) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Metadata: valid/dirty/PLRU and the latched miss context.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            vict_q     <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            if (miss_go) begin
                vict_q     <= victim;
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
            if (hit_go) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                if (bus.mem_write && (bus.mem_byte_enable != 2'b00))
                    dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[miss_idx_q][vict_q] <= 1'b1;
                dirty_q[miss_idx_q][vict_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hit_go && bus.mem_write) data_q[req_idx][hit_way] <= merge_line;
        if (fill_done) begin
            data_q[miss_idx_q][vict_q] <= bus.pmem_rdata;
            tag_q[miss_idx_q][vict_q]  <= miss_tag_q;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_go  && hit_count  != 32'hFFFF_FFFF) hit_count  <= hit_count  + 32'd1;
            if (miss_go && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            if (wb_done && wb_count   != 32'hFFFF_FFFF) wb_count   <= wb_count   + 32'd1;
        end
    end
`else
    // Counters absent; wb_done only feeds them.
    logic unused_wb_done;
    assign unused_wb_done = wb_done;
`endif
endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache: datapath and control FSM in one block.
- Sits between the LC-3b pipeline memory port and physical memory. Used as both I-cache and D-cache.
- Successor to the fixed 2-way/8-set D-cache datapath. Generalised in ways, sets and line size; adds tree pseudo-LRU, invalid-way-first victim choice and synchronous reset of all state.

Parameters:
- NUM_WAYS, 2, associativity; power of two, 2..8
- NUM_SETS, 8, sets; power of two, 2..64
- LINE_WORDS, 8, 16-bit words per line; power of two; line = 16*LINE_WORDS bits
- ADDR_WIDTH, 16, byte address width
- Derived: OFF = log2(LINE_WORDS)+1; IDX = log2(NUM_SETS); TAG = ADDR_WIDTH-IDX-OFF

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_address  in  ADDR_WIDTH  CPU byte address
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- mem_byte_enable  in  2  byte lanes for write; [0]=low byte
- mem_wdata  in  16  CPU write word
- mem_rdata  out  16  CPU read word
- mem_resp  out  1  CPU request complete
- pmem_address  out  ADDR_WIDTH  line-aligned physical address
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  16*LINE_WORDS  victim line
- pmem_rdata  in  16*LINE_WORDS  fill line
- pmem_resp  in  1  physical memory complete

Behaviour:
- Address split: offset [OFF-1:0], word select [OFF-1:1], index [OFF+IDX-1:OFF], tag the remaining upper bits.
- Per set: NUM_WAYS x {valid, dirty, tag, line}, plus NUM_WAYS-1 tree-PLRU bits. Arrays read asynchronously, write on clk edge.
- Reset (rst=1 at edge): all valid, dirty and PLRU bits cleared; FSM to IDLE. Outputs mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, mem_rdata=0. Line/tag contents are don't-care.
- Reset mid-operation: the current miss is abandoned; strobes low the following cycle; no partial line installed.
- FSM states are IDLE, WRITEBACK, FILL.
- IDLE, hit = valid && tag match in any way (at most one matches). mem_resp=1 combinationally in the same cycle:
  - Read: mem_rdata = selected word.
  - Write: enabled bytes merged into the line at the edge; dirty set only if mem_byte_enable!=0.
  - PLRU updated toward the hit way.
- IDLE, miss: victim = lowest-index invalid way, else the PLRU way.
  - Victim valid && dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK: pmem_write=1; pmem_address={victim tag, index, 0}; pmem_wdata=victim line. Held until pmem_resp=1, then -> FILL.
- FILL: pmem_read=1; pmem_address={req tag, index, 0}. On pmem_resp:
  - line, tag and valid=1 written into the victim way; dirty=0.
  - -> IDLE, where the request re-evaluates as a hit. Miss latency = WB cycles + fill cycles + 1.
- pmem_read and pmem_write are never asserted together. mem_resp=0 outside IDLE.
- mem_read && mem_write together is illegal; write takes priority.
- Request dropped mid-miss: the miss still completes. Return to IDLE with no mem_resp.
- PLRU: each node bit points to the less-recently-used subtree. On an access to way w, set each bit along the path to point away from w. On a miss with all ways valid, follow the bits to the victim.
- pmem_address=0 in IDLE.

Optional Feature:
- CACHE_PERF_CNT_EN defined: adds outputs hit_count[31:0], miss_count[31:0] and wb_count[31:0], plus input perf_clear.
  - hit_count increments on each IDLE hit response.
  - miss_count increments on each IDLE->miss transition.
  - wb_count increments on each WRITEBACK completion.
  - Counters saturate at 0xFFFFFFFF and clear on rst or perf_clear.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold read (defaults): rst, read 0x1234 -> pmem_read with pmem_address=0x1230. Respond with word2=0xBEEF -> back in IDLE, mem_resp=1, mem_rdata=0xBEEF, no pmem_write.
- Write hit: read 0x1234, then write 0x1234 with be=01, wdata=0x00AA -> same-cycle mem_resp. A following read returns 0xBEAA.
- Dirty eviction (NUM_WAYS=2): write 0x0010, read 0x0090, then read 0x0110 -> WRITEBACK to 0x0010 carrying the written word, then FILL from 0x0110.
- PLRU (NUM_WAYS=4): read 0x0000, 0x0080, 0x0100, 0x0180, then 0x0000 again, then 0x0200 -> victim is way 2 (0x0100). A later read of 0x0000 still hits.
- Reset mid-FILL: assert rst while pmem_read=1 -> next cycle pmem_read=0, mem_resp=0. A re-read of the same address misses again.
- Byte enable 00 write hit: line unchanged, dirty stays 0. Eviction of that line issues no pmem_write.
